// File: rtl/mult_share_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mult_share_pkg
//  Description : Shared types, default sizes and the rotating-priority search
//                used by the multiplier-sharing scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_share_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 32;
  localparam int LAT_DEF  = 2;

  // Widest supported requester population; tags and picks are sized for it
  localparam int NREQ_MAX = 16;
  localparam int IDW_MAX  = 4;

  // One in-flight operation travelling alongside the multiplier pipeline
  typedef struct packed {
    logic               valid;
    logic [IDW_MAX-1:0] id;
  } tag_t;

  // Result of a rotating-priority search
  typedef struct packed {
    logic               found;
    logic [IDW_MAX-1:0] idx;
  } rr_pick_t;

  // First set bit of elig scanning ptr, ptr+1, ... modulo nreq
  function automatic rr_pick_t rr_first(input logic [NREQ_MAX-1:0] elig,
                                        input logic [IDW_MAX-1:0]  ptr,
                                        input int                  nreq);
    rr_pick_t           pick;
    int                 idx;
    logic [IDW_MAX-1:0] idx_n;
    pick = '0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx   = (int'(ptr) + k) % nreq;
      idx_n = idx[IDW_MAX-1:0];
      if ((k < nreq) && !pick.found && elig[idx_n]) begin
        pick.found = 1'b1;
        pick.idx   = idx_n;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_share_sched_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : NREQ-wide rotating-priority picker. Grant is combinational;
//                the priority pointer moves past each winner on the grant edge.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] elig,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id,
  output logic [NREQ-1:0] grant_onehot
);

  logic [IDW-1:0]      ptr;
  logic [NREQ_MAX-1:0] elig_ext;
  logic [IDW_MAX-1:0]  ptr_ext;
  rr_pick_t            pick;
  logic                unused_pick_bits;

  // Search from the pointer and present the winner as index and one-hot
  always_comb begin
    elig_ext            = '0;
    elig_ext[NREQ-1:0]  = elig;
    ptr_ext             = '0;
    ptr_ext[IDW-1:0]    = ptr;
    pick                = rr_first(elig_ext, ptr_ext, NREQ);
    grant_valid         = pick.found;
    grant_id            = pick.idx[IDW-1:0];
    grant_onehot        = '0;
    if (pick.found) begin
      grant_onehot[grant_id] = 1'b1;
    end
  end

  assign unused_pick_bits = ^pick.idx;

  // Next search starts just after the most recent winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mult_share_sched
//  Description : Shares one pipelined multiplier among NREQ requesters.
//                One issue per cycle, one outstanding op per requester, and a
//                tag pipeline that routes each product back to its owner.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_share_sched
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int IDW  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_mx,
  input  logic [NREQ*W-1:0] req_my,
  output logic [W-1:0]      m_mx,
  output logic [W-1:0]      m_my,
  input  logic [2*W-1:0]    m_product,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_product,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [31:0]       op_count
);

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] pending_nxt;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant_onehot;
  logic [NREQ-1:0] rsp_onehot;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;
  logic [W-1:0]    sel_mx;
  logic [W-1:0]    sel_my;
  tag_t            tag_in;
  tag_t            tag_out;
  tag_t            tag_pipe [LAT+1];
  logic            unused_tag_bits;

  // A requester with an op still in flight may not be granted again
  assign elig = req_valid & ~pending;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk          (CLK),
    .rst_n        (RST),
    .elig         (elig),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot)
  );

  assign req_ready = grant_onehot & {NREQ{RST}};

  // Operand mux driven by the one-hot grant
  always_comb begin
    sel_mx = '0;
    sel_my = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_onehot[i]) begin
        sel_mx = req_mx[i*W +: W];
        sel_my = req_my[i*W +: W];
      end
    end
  end

  // Tag entering the pipeline and the owner decode of the tag leaving it
  always_comb begin
    tag_in              = '0;
    tag_in.valid        = grant_valid;
    tag_in.id[IDW-1:0]  = grant_id;
    tag_out             = tag_pipe[LAT];
    rsp_onehot          = '0;
    if (tag_out.valid) begin
      rsp_onehot[tag_out.id[IDW-1:0]] = 1'b1;
    end
    pending_nxt = (pending & ~rsp_onehot) | grant_onehot;
  end

  assign unused_tag_bits = ^tag_out.id;

  // Issue side: operand registers, ownership flags, busy and issue counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_mx     <= '0;
      m_my     <= '0;
      pending  <= '0;
      busy     <= 1'b0;
      op_count <= '0;
    end else begin
      if (grant_valid) begin
        m_mx     <= sel_mx;
        m_my     <= sel_my;
        op_count <= op_count + 32'd1;
      end
      pending <= pending_nxt;
      busy    <= |pending_nxt;
    end
  end

  // Tag pipeline: LAT+1 stages so the tag exits as m_product is sampled
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k <= LAT; k++) begin
        tag_pipe[k] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int k = 1; k <= LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  // Response register: product and owner captured only for a live tag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      rsp_valid <= rsp_onehot;
      if (tag_out.valid) begin
        rsp_product <= m_product;
        rsp_id      <= tag_out.id[IDW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mult_share_sched
//  Description : Self-checking bench for mult_share_sched with a multiplier
//                model and a transaction-level reference of the scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int LAT  = 2;
  localparam int IDW  = 2;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_mx;
  logic [NREQ*W-1:0] req_my;
  logic [W-1:0]      m_mx;
  logic [W-1:0]      m_my;
  logic [2*W-1:0]    m_product;
  logic [NREQ-1:0]   rsp_valid;
  logic [2*W-1:0]    rsp_product;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [31:0]       op_count;

  logic [W-1:0] mx_v [NREQ];
  logic [W-1:0] my_v [NREQ];

  mult_share_sched #(
    .NREQ (NREQ),
    .W    (W),
    .LAT  (LAT),
    .IDW  (IDW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mx      (req_mx),
    .req_my      (req_my),
    .m_mx        (m_mx),
    .m_my        (m_my),
    .m_product   (m_product),
    .rsp_valid   (rsp_valid),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .busy        (busy),
    .op_count    (op_count)
  );

  always #5 CLK = ~CLK;

  // Pack per-requester operands onto the flat buses
  always_comb begin
    req_mx = '0;
    req_my = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_mx[i*W +: W] = mx_v[i];
      req_my[i*W +: W] = my_v[i];
    end
  end

  // External multiplier: LAT-cycle pipeline from m_mx/m_my to m_product
  logic [2*W-1:0] mul_stage [LAT];
  always @(posedge CLK) begin
    mul_stage[0] <= {32'b0, m_mx} * {32'b0, m_my};
    for (int k = 1; k < LAT; k++) mul_stage[k] <= mul_stage[k-1];
  end
  assign m_product = mul_stage[LAT-1];

  // Reference model: list of outstanding ops with their response cycle
  typedef struct {
    int          id;
    logic [63:0] prod;
    int          due;
  } op_t;

  op_t             inflight [$];
  int              cyc;
  int              ptr_m;
  logic [31:0]     cnt_m;
  logic [NREQ-1:0] exp_rsp_valid;
  logic [63:0]     exp_rsp_prod;
  logic [IDW-1:0]  exp_rsp_id;
  int              n_checks = 0;
  int              n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit owner_busy(input int i);
    foreach (inflight[j]) if (inflight[j].id == i) return 1'b1;
    return 1'b0;
  endfunction

  // Called at a negedge with inputs already set; compares, clocks, advances model
  task automatic step();
    int              g;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr_m + k) % NREQ;
      if (g < 0 && req_valid[i] && !owner_busy(i)) g = i;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready",   64'(req_ready),   64'(exp_ready));
    check("rsp_valid",   64'(rsp_valid),   64'(exp_rsp_valid));
    check("rsp_product", rsp_product,      exp_rsp_prod);
    check("rsp_id",      64'(rsp_id),      64'(exp_rsp_id));
    check("busy",        64'(busy),        64'(inflight.size() != 0));
    check("op_count",    64'(op_count),    64'(cnt_m));
    @(posedge CLK);
    cyc++;
    if (g >= 0) begin
      inflight.push_back('{g, {32'b0, mx_v[g]} * {32'b0, my_v[g]}, cyc + LAT + 1});
      ptr_m = (g + 1) % NREQ;
      cnt_m = cnt_m + 32'd1;
    end
    exp_rsp_valid = '0;
    for (int j = inflight.size() - 1; j >= 0; j--) begin
      if (inflight[j].due == cyc) begin
        exp_rsp_valid[inflight[j].id] = 1'b1;
        exp_rsp_prod                  = inflight[j].prod;
        exp_rsp_id                    = IDW'(inflight[j].id);
        inflight.delete(j);
      end
    end
    @(negedge CLK);
  endtask

  // Assert reset at a negedge for 'hold' cycles; everything in flight is lost
  task automatic apply_reset(input int hold);
    RST = 1'b0;
    #1;
    inflight.delete();
    ptr_m         = 0;
    cnt_m         = '0;
    exp_rsp_valid = '0;
    exp_rsp_prod  = '0;
    exp_rsp_id    = '0;
    check("rst_ready",    64'(req_ready),  64'(0));
    check("rst_rsp",      64'(rsp_valid),  64'(0));
    check("rst_count",    64'(op_count),   64'(0));
    check("rst_busy",     64'(busy),       64'(0));
    check("rst_product",  rsp_product,     64'(0));
    repeat (hold) @(negedge CLK);
    check("rst_ready_hold", 64'(req_ready), 64'(0));
    RST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RST       = 1'b1;
    req_valid = '0;
    cyc       = 0;
    for (int i = 0; i < NREQ; i++) begin
      mx_v[i] = '0;
      my_v[i] = '0;
    end
    @(negedge CLK);

    // Reset with every requester asking; first edge after release grants 0
    req_valid = '1;
    apply_reset(2);
    step();
    req_valid = '0;
    repeat (5) step();

    // Single op from requester 2
    mx_v[2]   = 32'hFFFF_FFFF;
    my_v[2]   = 32'h0000_0002;
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    repeat (4) step();
    check("single_product", rsp_product, 64'h0000_0001_FFFF_FFFE);
    check("single_id", 64'(rsp_id), 64'(2));

    // Round robin across all four
    apply_reset(1);
    for (int i = 0; i < NREQ; i++) begin
      mx_v[i] = 32'(i + 1);
      my_v[i] = 32'd10;
    end
    req_valid = '1;
    repeat (4) step();
    req_valid = '0;
    repeat (5) step();
    check("rr_count", 64'(op_count), 64'(4));
    check("rr_last_product", rsp_product, 64'd40);

    // Requester 1 holds valid continuously
    mx_v[1]   = 32'h1234_5678;
    my_v[1]   = 32'h9ABC_DEF0;
    req_valid = 4'b0010;
    repeat (12) step();
    req_valid = '0;
    repeat (5) step();

    // Reset while requester 3's op is in flight
    apply_reset(1);
    mx_v[3]   = 32'd7;
    my_v[3]   = 32'd9;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    apply_reset(1);
    repeat (6) step();
    check("midrst_busy", 64'(busy), 64'(0));

    // Counter wrap
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    cnt_m     = 32'hFFFF_FFFF;
    mx_v[0]   = 32'd3;
    my_v[0]   = 32'd5;
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    check("wrap_count", 64'(op_count), 64'(0));
    repeat (4) step();

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        mx_v[i] = $urandom;
        my_v[i] = $urandom;
      end
      if ($urandom_range(0, 99) == 0) apply_reset(1);
      step();
    end
    req_valid = '0;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
